// File: rtl/enemy_motion_scheduler.sv
// rtl/enemy_motion_scheduler.sv - bouncing-enemy position scheduler, one shared update unit
//
// Purpose:
//   Holds the x/y centres and direction bits for N_ENEMY bouncing enemies.
//   A single bounce-and-step unit is time-shared across the enemies, one
//   enemy per clock. A sweep over all enemies starts once per game tick.
//   The game tick is a clock enable derived from clk by a wrapping counter.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   gamemenu     mode select: menu  ({menu,run,pause} = 100)
//   gamerun      mode select: run   (010)
//   gamepause    mode select: pause (001)
//   x_bus        packed x centres, enemy i in bits [10*i+9:10*i]
//   y_bus        packed y centres, same packing as x_bus
//   busy         high while a sweep is updating enemies
//   update_done  one-cycle pulse after the last enemy of a sweep is written

module enemy_motion_scheduler #(
  parameter int N_ENEMY  = 3,
  parameter int TICK_DIV = 100_000_000,
  parameter int STEP     = 20,
  parameter int HALF     = 10,
  parameter int X_MIN    = 15,
  parameter int X_MAX    = 626,
  parameter int Y_MIN    = 15,
  parameter int Y_MAX    = 466,
  parameter logic [10*N_ENEMY-1:0] INIT_X = {10'd200, 10'd450, 10'd300},
  parameter logic [10*N_ENEMY-1:0] INIT_Y = {10'd300, 10'd100, 10'd200}
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   gamemenu,
  input  logic                   gamerun,
  input  logic                   gamepause,
  output logic [10*N_ENEMY-1:0]  x_bus,
  output logic [10*N_ENEMY-1:0]  y_bus,
  output logic                   busy,
  output logic                   update_done
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ENEMY - 1);

  // Wall test arithmetic is done in 12-bit signed so x-HALF never wraps.
  localparam logic signed [11:0] STEP_S  = 12'(STEP);
  localparam logic signed [11:0] HALF_S  = 12'(HALF);
  localparam logic signed [11:0] X_MIN_S = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
  localparam logic signed [11:0] Y_MIN_S = 12'(Y_MIN);
  localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] tick_cnt;
  logic [IDX_W-1:0] idx;
  logic             pending;

  logic [9:0] x_q   [N_ENEMY];
  logic [9:0] y_q   [N_ENEMY];
  logic       dir_x [N_ENEMY];   // 1 = positive direction
  logic       dir_y [N_ENEMY];

  logic [2:0] mode;
  logic       mode_menu;
  logic       mode_run;
  logic       tick;

  logic [9:0] nxt_x;
  logic [9:0] nxt_y;
  logic       nxt_dx;
  logic       nxt_dy;

  assign mode      = {gamemenu, gamerun, gamepause};
  assign mode_menu = (mode == 3'b100);
  assign mode_run  = (mode == 3'b010);
  assign tick      = (tick_cnt == CNT_LAST);

  // Returns {new_dir, new_pos}. The direction is chosen first, then the step
  // is taken in the freshly chosen direction.
  function automatic logic [10:0] bounce(input logic [9:0] pos,
                                         input logic dir,
                                         input logic signed [11:0] lo,
                                         input logic signed [11:0] hi);
    logic signed [11:0] p;
    logic               d;
    p = $signed({2'b00, pos});
    d = dir;
    if (p + HALF_S > hi)
      d = 1'b0;
    else if (p - HALF_S < lo)
      d = 1'b1;
    return {d, 10'(d ? (p + STEP_S) : (p - STEP_S))};
  endfunction

  // Shared update unit, always looking at the enemy selected by idx.
  always_comb begin
    nxt_x  = '0;
    nxt_y  = '0;
    nxt_dx = 1'b0;
    nxt_dy = 1'b0;
    {nxt_dx, nxt_x} = bounce(x_q[idx], dir_x[idx], X_MIN_S, X_MAX_S);
    {nxt_dy, nxt_y} = bounce(y_q[idx], dir_y[idx], Y_MIN_S, Y_MAX_S);
  end

  always_ff @(posedge clk) begin
    if (reset || mode_menu) begin
      // Menu behaves as a continuous reinit, so it also aborts a sweep.
      for (int i = 0; i < N_ENEMY; i++) begin
        x_q[i]   <= INIT_X[10*i +: 10];
        y_q[i]   <= INIT_Y[10*i +: 10];
        dir_x[i] <= 1'b1;
        dir_y[i] <= 1'b1;
      end
      tick_cnt    <= '0;
      state       <= S_IDLE;
      idx         <= '0;
      pending     <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
    end else begin
      // The tick counter free-runs in run, pause and illegal modes.
      tick_cnt    <= tick ? '0 : tick_cnt + 1'b1;
      update_done <= 1'b0;

      case (state)
        S_IDLE: begin
          // Mode is only consulted here; a started sweep always completes.
          if (mode_run && (tick || pending)) begin
            state   <= S_SWEEP;
            idx     <= '0;
            pending <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_SWEEP: begin
          x_q[idx]   <= nxt_x;
          y_q[idx]   <= nxt_y;
          dir_x[idx] <= nxt_dx;
          dir_y[idx] <= nxt_dy;
          // A tick arriving mid-sweep is remembered once; extra ticks drop.
          if (tick && mode_run)
            pending <= 1'b1;
          if (idx == IDX_LAST) begin
            state       <= S_DONE;
            busy        <= 1'b0;
            update_done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        S_DONE: begin
          if (tick && mode_run)
            pending <= 1'b1;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < N_ENEMY; gi++) begin : g_bus
    assign x_bus[10*gi +: 10] = x_q[gi];
    assign y_bus[10*gi +: 10] = y_q[gi];
  end

endmodule

// File: tb/tb_enemy_motion_scheduler.sv
// tb/tb_enemy_motion_scheduler.sv - directed vector bench for enemy_motion_scheduler

module tb_enemy_motion_scheduler;

  localparam logic [2:0] M_MENU  = 3'b100;
  localparam logic [2:0] M_RUN   = 3'b010;
  localparam logic [2:0] M_PAUSE = 3'b001;
  localparam logic [2:0] M_ILL   = 3'b110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, gamemenu, gamerun, gamepause;
  logic [29:0] x_bus, y_bus;
  logic        busy, update_done;

  logic        reset_b;
  logic [29:0] x_bus_b, y_bus_b;
  logic        busy_b, update_done_b;

  enemy_motion_scheduler #(.TICK_DIV(8)) dut (
    .clk(clk), .reset(reset),
    .gamemenu(gamemenu), .gamerun(gamerun), .gamepause(gamepause),
    .x_bus(x_bus), .y_bus(y_bus), .busy(busy), .update_done(update_done)
  );

  // Short tick period so that a tick lands exactly in the DONE cycle.
  enemy_motion_scheduler #(.TICK_DIV(4)) dut_b (
    .clk(clk), .reset(reset_b),
    .gamemenu(1'b0), .gamerun(1'b1), .gamepause(1'b0),
    .x_bus(x_bus_b), .y_bus(y_bus_b), .busy(busy_b), .update_done(update_done_b)
  );

  typedef struct {
    logic [2:0]  mode;
    logic        busy;
    logic        done;
    logic [29:0] x;
    logic [29:0] y;
  } vec_t;

  vec_t tab[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [29:0] X0  = {10'd200, 10'd450, 10'd300};
  localparam logic [29:0] Y0  = {10'd300, 10'd100, 10'd200};
  localparam logic [29:0] X1A = {10'd200, 10'd450, 10'd320};
  localparam logic [29:0] Y1A = {10'd300, 10'd100, 10'd220};
  localparam logic [29:0] X1B = {10'd200, 10'd470, 10'd320};
  localparam logic [29:0] Y1B = {10'd300, 10'd120, 10'd220};
  localparam logic [29:0] X1  = {10'd220, 10'd470, 10'd320};
  localparam logic [29:0] Y1  = {10'd320, 10'd120, 10'd220};
  localparam logic [29:0] X2A = {10'd220, 10'd470, 10'd340};
  localparam logic [29:0] Y2A = {10'd320, 10'd120, 10'd240};
  localparam logic [29:0] X2B = {10'd220, 10'd490, 10'd340};
  localparam logic [29:0] Y2B = {10'd320, 10'd140, 10'd240};
  localparam logic [29:0] X2  = {10'd240, 10'd490, 10'd340};
  localparam logic [29:0] Y2  = {10'd340, 10'd140, 10'd240};
  localparam logic [29:0] X3A = {10'd240, 10'd490, 10'd360};
  localparam logic [29:0] Y3A = {10'd340, 10'd140, 10'd260};

  task automatic add(input logic [2:0] m, input logic b, input logic d,
                     input logic [29:0] x, input logic [29:0] y, input int n);
    vec_t v;
    v.mode = m; v.busy = b; v.done = d; v.x = x; v.y = y;
    repeat (n) tab.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic set_mode(input logic [2:0] m);
    {gamemenu, gamerun, gamepause} = m;
  endtask

  // Spec bounce rule, applied in plain integer arithmetic.
  int mx[3], my[3];
  int mdx[3], mdy[3];

  function automatic void model_axis(inout int p, inout int d, input int lo, input int hi);
    if (p + 10 > hi) d = 0;
    else if (p - 10 < lo) d = 1;
    p = (d != 0) ? p + 20 : p - 20;
    p = p & 1023;
  endfunction

  function automatic logic [29:0] pack3(input int a0, input int a1, input int a2);
    return {10'(a2), 10'(a1), 10'(a0)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int w;
    logic [15:0] busy_mask;
    logic [15:0] done_mask;

    reset = 1'b1;
    reset_b = 1'b1;
    set_mode(M_RUN);

    // Row j: mode during cycle j, outputs expected during cycle j+1.
    add(M_RUN,   0, 0, X0,  Y0,  7);   // j 0..6   idle before first tick
    add(M_RUN,   1, 0, X0,  Y0,  1);   // j 7      tick -> sweep starts
    add(M_RUN,   1, 0, X1A, Y1A, 1);   // enemy 0 written
    add(M_RUN,   1, 0, X1B, Y1B, 1);   // enemy 1 written
    add(M_RUN,   0, 1, X1,  Y1,  1);   // enemy 2 written, done pulse
    add(M_RUN,   0, 0, X1,  Y1,  1);   // j 11     pulse is single-cycle
    add(M_PAUSE, 0, 0, X1,  Y1,  24);  // j 12..35 three ticks ignored
    add(M_RUN,   0, 0, X1,  Y1,  3);   // j 36..38
    add(M_RUN,   1, 0, X1,  Y1,  1);   // j 39     tick in run
    add(M_RUN,   1, 0, X2A, Y2A, 1);
    add(M_RUN,   1, 0, X2B, Y2B, 1);
    add(M_RUN,   0, 1, X2,  Y2,  1);
    add(M_RUN,   0, 0, X2,  Y2,  4);   // j 43..46
    add(M_RUN,   1, 0, X2,  Y2,  1);   // j 47     tick
    add(M_RUN,   1, 0, X3A, Y3A, 1);   // j 48     first sweep cycle
    add(M_MENU,  0, 0, X0,  Y0,  4);   // j 49..52 menu on second sweep cycle
    add(M_ILL,   0, 0, X0,  Y0,  10);  // j 53..62 tick at cycle 60 ignored

    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("reset_x", {2'b0, x_bus}, {2'b0, X0});
    check("reset_y", {2'b0, y_bus}, {2'b0, Y0});
    check("reset_busy_done", {30'b0, busy, update_done}, 32'd0);

    for (int j = 0; j < tab.size(); j++) begin
      set_mode(tab[j].mode);
      @(negedge clk);
      check($sformatf("vec%0d_x", j), {2'b0, x_bus}, {2'b0, tab[j].x});
      check($sformatf("vec%0d_y", j), {2'b0, y_bus}, {2'b0, tab[j].y});
      check($sformatf("vec%0d_busy_done", j), {30'b0, busy, update_done},
            {30'b0, tab[j].busy, tab[j].done});
    end

    // Long run from the init state to walk enemies into every wall.
    set_mode(M_RUN);
    mx[0] = 300; mx[1] = 450; mx[2] = 200;
    my[0] = 200; my[1] = 100; my[2] = 300;
    for (int i = 0; i < 3; i++) begin
      mdx[i] = 1; mdy[i] = 1;
    end
    for (int n = 1; n <= 47; n++) begin
      w = 0;
      while (!update_done && w < 20) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("sweep%0d_done_seen", n), {31'b0, update_done}, 32'd1);
      for (int i = 0; i < 3; i++) begin
        model_axis(mx[i], mdx[i], 15, 626);
        model_axis(my[i], mdy[i], 15, 466);
      end
      check($sformatf("sweep%0d_x", n), {2'b0, x_bus}, {2'b0, pack3(mx[0], mx[1], mx[2])});
      check($sformatf("sweep%0d_y", n), {2'b0, y_bus}, {2'b0, pack3(my[0], my[1], my[2])});
      if (n == 13) check("wall_y_460", {22'b0, y_bus[9:0]}, 32'd460);
      if (n == 14) check("wall_y_440", {22'b0, y_bus[9:0]}, 32'd440);
      if (n == 16) check("wall_x_620", {22'b0, x_bus[9:0]}, 32'd620);
      if (n == 17) check("wall_x_600", {22'b0, x_bus[9:0]}, 32'd600);
      if (n == 46) check("wall_x_20",  {22'b0, x_bus[9:0]}, 32'd20);
      if (n == 47) check("wall_x_40",  {22'b0, x_bus[9:0]}, 32'd40);
      @(negedge clk);
    end

    // Tick lands in DONE: pending is set and the next sweep follows after one idle cycle.
    busy_mask = 16'h4E70;   // cycles 4,5,6,9,10,11,14
    done_mask = 16'h1080;   // cycles 7,12
    reset_b = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("b_cyc%0d_busy", k), {31'b0, busy_b}, {31'b0, busy_mask[k]});
      check($sformatf("b_cyc%0d_done", k), {31'b0, update_done_b}, {31'b0, done_mask[k]});
      if (k == 8) begin
        check("b_sweep1_x", {2'b0, x_bus_b}, {2'b0, X1});
        check("b_sweep1_y", {2'b0, y_bus_b}, {2'b0, Y1});
      end
      if (k == 13) begin
        check("b_sweep2_x", {2'b0, x_bus_b}, {2'b0, X2});
        check("b_sweep2_y", {2'b0, y_bus_b}, {2'b0, Y2});
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
